uart_rx_axis: RTL and testbench
===============================

UART_RX_AXIS -- requirements
Module: uart_rx_axis

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50_000_000, input clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, line rate in bit/s.
REQ-003 SHALL have parameter OVERSAMPLE, default 16, sample ticks per bit, legal values 8 or 16.
REQ-004 SHALL have parameter DATA_BITS, default 8, data bits per frame, legal range 5..9.
REQ-005 SHALL have parameter PARITY, default "even", legal values "none", "even" or "odd".
REQ-006 SHALL have parameter FIFO_DEPTH, default 16, output FIFO entries, a power of 2 and at least 2.
REQ-007 SHALL have port clk, input, 1 bit, the single clock.
REQ-008 SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-009 SHALL have port rx, input, 1 bit, asynchronous serial line, idle high.
REQ-010 SHALL have port m_axis_tdata, output, DATA_BITS bits, received word.
REQ-011 SHALL have port m_axis_tuser, output, 2 bits, {framing_err, parity_err} for the word.
REQ-012 SHALL have port m_axis_tvalid, output, 1 bit, FIFO not empty.
REQ-013 SHALL have port m_axis_tready, input, 1 bit, consumer accepts the word.
REQ-014 SHALL have port rx_overrun, output, 1 bit, 1-cycle pulse when a word is dropped because the FIFO is full.
REQ-015 SHALL have port rx_break, output, 1 bit, break indication, present only under REQ-036.

Function
REQ-016 SHALL pass rx through a 2-flop synchroniser with both flops at 1 after reset, and use only the synchronised value.
REQ-017 SHALL generate a sample tick every TICK_DIV = CLK_FREQ/(BAUD*OVERSAMPLE) clocks, using integer division, with TICK_DIV >= 1 enforced at elaboration.
REQ-018 SHALL use FSM states IDLE, START, DATA, PARITY, STOP.
REQ-019 SHALL leave IDLE for START on the first tick at which rx is low, and reset the tick phase counter at that point.
REQ-020 SHALL form every bit decision as the majority of 3 consecutive samples centred on tick OVERSAMPLE/2 of the bit.
REQ-021 START SHALL return to IDLE with no output when the mid-bit vote is 1 (false start); otherwise it SHALL go to DATA.
REQ-022 DATA SHALL shift in LSB first, DATA_BITS votes; then go to PARITY, or go to STOP when PARITY="none".
REQ-023 parity_err SHALL be set to (XOR of data bits XOR parity bit) != 0 for "even" and == 0 for "odd"; it SHALL be 0 for "none".
REQ-024 framing_err SHALL be 1 when the stop-bit vote is 0.
REQ-025 STOP SHALL, on the cycle after the stop-bit vote, push {tuser, data} into the FIFO and return to IDLE; words with errors SHALL still be pushed.
REQ-026 After framing_err, IDLE SHALL wait for rx high before it accepts a new start bit.
REQ-027 m_axis_tvalid SHALL rise the cycle after a push into an empty FIFO, with no bypass path.
REQ-028 A pop SHALL occur when m_axis_tvalid and m_axis_tready are both high; tdata and tuser SHALL hold while tvalid=1 and tready=0.
REQ-029 A push to a full FIFO without a simultaneous pop SHALL drop the new word, leave stored words untouched and pulse rx_overrun.
REQ-030 A push and a pop in the same cycle SHALL both succeed at any fill level, including full.
REQ-031 FIFO pointers SHALL be log2(FIFO_DEPTH)+1 bits and wrap modulo 2*FIFO_DEPTH; full and empty SHALL be derived from the extra MSB.

Reset
REQ-032 rst SHALL put the FSM in IDLE and clear the tick counter, bit counter, shift register and FIFO pointers.
REQ-033 After rst, outputs SHALL be m_axis_tvalid=0, m_axis_tdata=0, m_axis_tuser=0, rx_overrun=0 and rx_break=0.
REQ-034 rst asserted mid-frame SHALL discard the partial word; after release, reception SHALL resume only at the next falling edge following an rx-high sample.

Configuration
REQ-035 Macro UART_RX_BREAK_DET_EN SHALL control break detection.
REQ-036 With UART_RX_BREAK_DET_EN defined: if rx stays low for the whole frame (start, data, parity and stop all 0), the FSM SHALL push nothing, assert rx_break until rx returns high, then return to IDLE.
REQ-037 Without UART_RX_BREAK_DET_EN: port rx_break SHALL be absent and such a frame SHALL be pushed as data 0 with framing_err=1.

Structure
REQ-038 Package uart_pkg SHALL hold the FSM state enum, the parity-mode encoding, the tuser bit indices and the TICK_DIV calculation function.
REQ-039 The FIFO SHALL be a separate sub-module, uart_rx_fifo, with parameters WIDTH and DEPTH and a registered read output.

Verification
Bench settings for all scenarios: CLK_FREQ=50e6, BAUD=115200, OVERSAMPLE=16, so TICK_DIV=27.
REQ-040 Even parity, frame 0xA5 with parity bit 0, tready=1 -> tdata=0xA5, tuser=00, exactly one tvalid beat.
REQ-041 Frame 0x3C with the parity bit flipped -> tdata=0x3C, tuser=01; frame 0x3C with stop bit 0 -> tuser=10.
REQ-042 A 3-tick low glitch on idle rx -> no push, FSM back in IDLE, tvalid stays 0.
REQ-043 FIFO_DEPTH=4, tready=0, 5 frames 0x01..0x05 -> 4 words held, one rx_overrun pulse; draining yields 0x01..0x04 in order.
REQ-044 rst asserted at data bit 3 of 0xFF, then frame 0x12 -> only 0x12 is output.
REQ-045 With UART_RX_BREAK_DET_EN, rx held low for 20 bit times -> rx_break=1 until rx rises, no word pushed.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared types, tuser layout and divider arithmetic for the UART
// receiver slice (uart_rx_axis + uart_rx_fifo).
package uart_pkg;

  // Receiver FSM states. ST_BREAK is only reachable when break detection is
  // compiled in.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BREAK
  } rx_state_e;

  // Parity mode decoded from the PARITY string parameter.
  typedef enum logic [1:0] {
    PAR_NONE,
    PAR_EVEN,
    PAR_ODD
  } parity_e;

  // Bit positions inside m_axis_tuser = {framing_err, parity_err}.
  localparam int TUSER_PERR = 0;
  localparam int TUSER_FERR = 1;
  localparam int TUSER_W    = 2;

  // Clocks per sample tick, truncating integer division.
  function automatic int calc_tick_div(input int clk_freq, input int baud,
                                       input int oversample);
    return clk_freq / (baud * oversample);
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: synchronous FIFO with a registered head word. Pointers carry
// one extra wrap bit so full/empty come straight from the pointer MSBs.
module uart_rx_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop_ready,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  output logic             overrun
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
  logic             empty, full, pop, push_ok, head_valid;

  assign empty      = (wr_ptr == rd_ptr);
  assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop        = !empty && pop_ready;
  // A pop frees a slot in the same cycle, so push+pop succeeds even when full.
  assign push_ok    = push && (!full || pop);
  assign wr_ptr_n   = wr_ptr + PW'(push_ok);
  assign rd_ptr_n   = rd_ptr + PW'(pop);
  assign head_valid = (wr_ptr_n != rd_ptr_n);
  assign rd_valid   = !empty;

  // Pointers, head register and overrun pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      rd_data <= '0;
      overrun <= 1'b0;
    end else begin
      wr_ptr  <= wr_ptr_n;
      rd_ptr  <= rd_ptr_n;
      overrun <= push && full && !pop;
      // Head only reloads when a word will be present; it holds otherwise.
      if (head_valid) begin
        if (push_ok && (wr_ptr[AW-1:0] == rd_ptr_n[AW-1:0])) begin
          rd_data <= push_data;
        end else begin
          rd_data <= mem[rd_ptr_n[AW-1:0]];
        end
      end
    end
  end

  // Storage array write port.
  // NOTE: the array is not reset; a slot is only read after it was written,
  // so clearing it would cost reset fan-out for no behavioural change.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/uart_rx_axis.sv
// uart_rx_axis: oversampling UART receiver with majority-vote bit decisions,
// parity/framing flags and an AXI-Stream output FIFO.
// Optional break detection: define UART_RX_BREAK_DET_EN to add port rx_break;
// without it an all-zero frame is delivered as data 0 with framing_err set.
module uart_rx_axis
  import uart_pkg::*;
#(
  parameter int    CLK_FREQ   = 50_000_000,
  parameter int    BAUD       = 115200,
  parameter int    OVERSAMPLE = 16,
  parameter int    DATA_BITS  = 8,
  parameter string PARITY     = "even",
  parameter int    FIFO_DEPTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] m_axis_tdata,
  output logic [1:0]           m_axis_tuser,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic                 rx_overrun
`ifdef UART_RX_BREAK_DET_EN
  ,
  output logic                 rx_break
`endif
);

  localparam int      TICK_DIV = calc_tick_div(CLK_FREQ, BAUD, OVERSAMPLE);
  localparam int      DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int      OS_W     = $clog2(OVERSAMPLE);
  localparam int      BIT_W    = $clog2(DATA_BITS);
  localparam int      WORD_W   = DATA_BITS + TUSER_W;
  localparam parity_e PAR_MODE = (PARITY == "none") ? PAR_NONE :
                                 (PARITY == "odd")  ? PAR_ODD  : PAR_EVEN;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);
  localparam logic [OS_W-1:0]  VOTE_POS = OS_W'(OVERSAMPLE / 2);

  if (TICK_DIV < 1) begin : g_bad_tick_div
    $error("uart_rx_axis: CLK_FREQ/(BAUD*OVERSAMPLE) must be at least 1");
  end
  if (OVERSAMPLE != 8 && OVERSAMPLE != 16) begin : g_bad_oversample
    $error("uart_rx_axis: OVERSAMPLE must be 8 or 16");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_rx_axis: DATA_BITS must be 5..9");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_rx_axis: FIFO_DEPTH must be a power of 2, at least 2");
  end

  rx_state_e          state, state_n;
  logic               rx_meta, rx_sync;
  logic [DIV_W-1:0]   div_cnt;
  logic [OS_W-1:0]    os_cnt;
  logic [1:0]         samp_sr;
  logic [BIT_W-1:0]   bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic               par_q, ferr_q, stop_seen, armed;
  logic               tick, vote, vote_tick, start_det, break_frame, perr, push;
  logic [WORD_W-1:0]  push_word, pop_word;

  // Two-flop synchroniser; both stages reset to the idle line level.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      // NOTE: non-blocking, so rx_sync takes the previous rx_meta and the
      // chain really is two flops deep.
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  // Sample-tick divider.
  always_ff @(posedge clk) begin
    if (rst || tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  assign tick      = (div_cnt == DIV_W'(TICK_DIV - 1));
  assign start_det = (state == ST_IDLE) && tick && !rx_sync && armed;

  // Tick phase within the current bit and the two samples preceding the
  // current one; phase restarts at the start-bit edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      os_cnt  <= '0;
      samp_sr <= 2'b11;
    end else if (tick) begin
      samp_sr <= {samp_sr[0], rx_sync};
      os_cnt  <= start_det ? '0 : os_cnt + 1'b1;
    end
  end

  // Samples OVERSAMPLE/2-1, OVERSAMPLE/2, OVERSAMPLE/2+1 are voted on the last.
  assign vote      = (samp_sr[1] & samp_sr[0]) | (samp_sr[1] & rx_sync) |
                     (samp_sr[0] & rx_sync);
  assign vote_tick = tick && (os_cnt == VOTE_POS);

  assign perr = (PAR_MODE == PAR_EVEN) ?  (^shreg ^ par_q) :
                (PAR_MODE == PAR_ODD)  ? ~(^shreg ^ par_q) : 1'b0;

`ifdef UART_RX_BREAK_DET_EN
  // Start, data, parity and stop all low: a line break, not a word.
  assign break_frame = vote_tick && !vote && (shreg == '0) && !par_q;
  assign rx_break    = (state == ST_BREAK);
`else
  assign break_frame = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // FSM next-state and push decode.
  always_comb begin
    // NOTE: defaults first so every path assigns both outputs; no latches.
    state_n = state;
    push    = 1'b0;
    case (state)
      ST_IDLE:   if (start_det) state_n = ST_START;
      ST_START:  if (vote_tick) state_n = vote ? ST_IDLE : ST_DATA;
      ST_DATA:   if (vote_tick && bit_cnt == LAST_BIT)
                   state_n = (PAR_MODE == PAR_NONE) ? ST_STOP : ST_PARITY;
      ST_PARITY: if (vote_tick) state_n = ST_STOP;
      ST_STOP: begin
        if (stop_seen) begin
          push    = 1'b1;
          state_n = ST_IDLE;
        end else if (break_frame) begin
          state_n = ST_BREAK;
        end
      end
      ST_BREAK:  if (rx_sync) state_n = ST_IDLE;
      default:   state_n = ST_IDLE;
    endcase
  end

  // Frame datapath: shift register, parity/stop capture, line-idle tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt   <= '0;
      shreg     <= '0;
      par_q     <= 1'b0;
      ferr_q    <= 1'b0;
      stop_seen <= 1'b0;
      armed     <= 1'b0;
    end else begin
      if (start_det) begin
        bit_cnt <= '0;
        par_q   <= 1'b0;
      end
      case (state)
        ST_IDLE:   if (tick && rx_sync) armed <= 1'b1;
        ST_DATA: begin
          if (vote_tick) begin
            shreg   <= {vote, shreg[DATA_BITS-1:1]};
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        ST_PARITY: if (vote_tick) par_q <= vote;
        ST_STOP: begin
          if (vote_tick && !stop_seen && !break_frame) begin
            stop_seen <= 1'b1;
            ferr_q    <= ~vote;
          end
          if (push) begin
            stop_seen <= 1'b0;
            // A low stop bit means the line may still be low: re-arm on high.
            armed     <= ~ferr_q;
          end
        end
        ST_BREAK:  if (rx_sync) armed <= 1'b1;
        default:   ;
      endcase
    end
  end

  // Word as stored in the FIFO: {tuser, data}.
  always_comb begin
    push_word                          = '0;
    push_word[DATA_BITS-1:0]           = shreg;
    push_word[DATA_BITS + TUSER_FERR]  = ferr_q;
    push_word[DATA_BITS + TUSER_PERR]  = perr;
  end

  uart_rx_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_word),
    .pop_ready (m_axis_tready),
    .rd_data   (pop_word),
    .rd_valid  (m_axis_tvalid),
    .overrun   (rx_overrun)
  );

  assign m_axis_tdata = pop_word[DATA_BITS-1:0];
  assign m_axis_tuser = pop_word[WORD_W-1:DATA_BITS];

endmodule

// File: tb/tb_uart_rx_axis.sv
// tb_uart_rx_axis: self-checking bench for uart_rx_axis (8E1, FIFO depth 4).
// Covers directed vectors, random frames against a parity/framing model,
// glitch rejection, overrun, mid-frame reset and all-low frames (break
// behaviour follows UART_RX_BREAK_DET_EN).
`timescale 1ns/1ps
module tb_uart_rx_axis;
  import uart_pkg::*;

  localparam int CLK_FREQ = 50_000_000;
  localparam int BAUD     = 115200;
  localparam int OS       = 16;
  localparam int TDIV     = CLK_FREQ / (BAUD * OS);  // 27
  localparam int BIT_CLKS = TDIV * OS;               // 432

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx = 1'b1;
  logic       tready = 1'b1;
  logic [7:0] tdata;
  logic [1:0] tuser;
  logic       tvalid, rx_overrun;
`ifdef UART_RX_BREAK_DET_EN
  logic       rx_break;
`endif

  int         checks = 0;
  int         errors = 0;
  int         ovr_cnt = 0;
  int         hold_viol = 0;
  logic       done;
  logic [9:0] got_q[$];
  logic [9:0] exp_q[$];
  logic       prev_stall = 1'b0;
  logic [9:0] prev_word = '0;

  uart_rx_axis #(
    .CLK_FREQ   (CLK_FREQ),
    .BAUD       (BAUD),
    .OVERSAMPLE (OS),
    .DATA_BITS  (8),
    .PARITY     ("even"),
    .FIFO_DEPTH (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .rx            (rx),
    .m_axis_tdata  (tdata),
    .m_axis_tuser  (tuser),
    .m_axis_tvalid (tvalid),
    .m_axis_tready (tready),
    .rx_overrun    (rx_overrun)
`ifdef UART_RX_BREAK_DET_EN
    ,
    .rx_break      (rx_break)
`endif
  );

  always #10 clk = ~clk;  // 50 MHz

  // Output monitor on the falling edge: accepted beats, overrun pulses and
  // stability of the word during back-pressure.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && ({tuser, tdata} !== prev_word)) hold_viol++;
      if (tvalid && tready) got_q.push_back({tuser, tdata});
      if (rx_overrun) ovr_cnt++;
      prev_stall = tvalid && !tready;
      prev_word  = {tuser, tdata};
    end
  end

  initial begin
    #4_000_000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #3;
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    wait_clks(BIT_CLKS);
  endtask

  // One 8E1-shaped frame with caller-chosen parity and stop bits, then idle.
  task automatic send_frame(input logic [7:0] d, input logic pbit, input logic stp);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(pbit);
    send_bit(stp);
    rx = 1'b1;
    wait_clks(stp ? BIT_CLKS / 2 : BIT_CLKS);
  endtask

  function automatic logic good_parity(input logic [7:0] d);
    return logic'($countones(d) % 2);
  endfunction

  // Reference: even parity means the total count of ones (data + parity bit)
  // must be even; a low stop bit is a framing error.
  function automatic logic [9:0] model_word(input logic [7:0] d, input logic pbit,
                                            input logic stp);
    int   ones;
    logic perr, ferr;
    ones = $countones(d) + int'(pbit);
    perr = (ones % 2) != 0;
    ferr = !stp;
    return {ferr, perr, d};
  endfunction

  function automatic logic is_break(input logic [7:0] d, input logic pbit, input logic stp);
`ifdef UART_RX_BREAK_DET_EN
    return (d == 8'h00) && !pbit && !stp;
`else
    return 1'b0;
`endif
  endfunction

  typedef struct {
    logic [7:0] data;
    logic       pbit;
    logic       stp;
    logic [7:0] exp_data;
    logic [1:0] exp_user;
  } vec_t;

  vec_t vecs[4];

  initial begin
    logic [7:0] d;
    logic       p, s;

    vecs[0] = '{8'hA5, 1'b0, 1'b1, 8'hA5, 2'b00};
    vecs[1] = '{8'h3C, 1'b1, 1'b1, 8'h3C, 2'b01};
    vecs[2] = '{8'h3C, 1'b0, 1'b0, 8'h3C, 2'b10};
    vecs[3] = '{8'h80, 1'b0, 1'b1, 8'h80, 2'b01};

    // Reset state.
    wait_clks(8);
    rst = 1'b0;
    wait_clks(2);
    check("rst_tvalid", tvalid, 0);
    check("rst_tdata", tdata, 0);
    check("rst_tuser", tuser, 0);
    check("rst_overrun", rx_overrun, 0);
`ifdef UART_RX_BREAK_DET_EN
    check("rst_break", rx_break, 0);
`endif
    wait_clks(BIT_CLKS);

    // Directed vectors, consumer always ready.
    for (int i = 0; i < 4; i++) begin
      got_q.delete();
      send_frame(vecs[i].data, vecs[i].pbit, vecs[i].stp);
      check($sformatf("vec%0d_beats", i), got_q.size(), 1);
      if (got_q.size() > 0) begin
        check($sformatf("vec%0d_tdata", i), got_q[0][7:0], vecs[i].exp_data);
        check($sformatf("vec%0d_tuser", i), got_q[0][9:8], vecs[i].exp_user);
      end
    end

    // Random frames with random back-pressure, against the reference model.
    got_q.delete();
    exp_q.delete();
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          d = 8'($urandom);
          p = good_parity(d) ^ ($urandom_range(0, 3) == 0);
          s = ($urandom_range(0, 4) != 0);
          if (!is_break(d, p, s)) exp_q.push_back(model_word(d, p, s));
          send_frame(d, p, s);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          wait_clks(1);
          tready = 1'($urandom_range(0, 1));
        end
      end
    join
    tready = 1'b1;
    for (int w = 0; w < 1000 && got_q.size() < exp_q.size(); w++) wait_clks(1);
    check("rand_count", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("rand_word%0d", i), got_q[i], exp_q[i]);

    // Short low glitch on an idle line.
    got_q.delete();
    rx = 1'b0;
    wait_clks(3 * TDIV);
    rx = 1'b1;
    wait_clks(2 * BIT_CLKS);
    check("glitch_beats", got_q.size(), 0);
    check("glitch_tvalid", tvalid, 0);
    check("glitch_state", 32'(dut.state), 32'(ST_IDLE));

    // Overrun: five frames into a stalled depth-4 FIFO.
    got_q.delete();
    ovr_cnt = 0;
    tready  = 1'b0;
    for (int k = 1; k <= 5; k++) send_frame(8'(k), good_parity(8'(k)), 1'b1);
    check("ovr_pulses", ovr_cnt, 1);
    check("ovr_tvalid", tvalid, 1);
    check("ovr_head", tdata, 8'h01);
    tready = 1'b1;
    for (int w = 0; w < 100 && got_q.size() < 4; w++) wait_clks(1);
    wait_clks(5);
    check("ovr_drain_count", got_q.size(), 4);
    for (int i = 0; i < 4 && i < got_q.size(); i++)
      check($sformatf("ovr_drain%0d", i), got_q[i], {2'b00, 8'(i + 1)});
    check("ovr_empty", tvalid, 0);

    // Reset during data bit 3 of 0xFF, then a clean 0x12.
    got_q.delete();
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    rx = 1'b1;
    wait_clks(BIT_CLKS / 2);
    rst = 1'b1;
    wait_clks(3);
    rst = 1'b0;
    wait_clks(1);
    check("midrst_tvalid", tvalid, 0);
    wait_clks(BIT_CLKS);
    send_frame(8'h12, good_parity(8'h12), 1'b1);
    check("midrst_beats", got_q.size(), 1);
    if (got_q.size() > 0) check("midrst_word", got_q[0], {2'b00, 8'h12});

    // Line held low for 20 bit times.
    got_q.delete();
    rx = 1'b0;
    wait_clks(20 * BIT_CLKS);
`ifdef UART_RX_BREAK_DET_EN
    check("break_high", rx_break, 1);
    rx = 1'b1;
    wait_clks(4);
    check("break_low", rx_break, 0);
    wait_clks(BIT_CLKS);
    check("break_beats", got_q.size(), 0);
`else
    rx = 1'b1;
    wait_clks(BIT_CLKS);
    check("lowline_beats", got_q.size(), 1);
    if (got_q.size() > 0) check("lowline_word", got_q[0], model_word(8'h00, 1'b0, 1'b0));
`endif

    check("hold_stable", hold_viol, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
